// File: rtl/pll_seq_pkg.sv
// Shared state encoding, default timing constants and helpers for the PLL reset sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAIL      = 3'd5
    } seq_state_e;

    localparam int DEF_PLL_RST_CYCLES = 16;
    localparam int DEF_LOCK_TIMEOUT   = 1024;
    localparam int DEF_STABLE_CYCLES  = 64;
    localparam int DEF_STAGE_GAP      = 8;
    localparam int DEF_MAX_RETRIES    = 3;

    // Domain reset patterns, bit 0 = SDRAM, bit 1 = frame buffer, bit 2 = video timing
    localparam logic [2:0] RST_ALL    = 3'b000;
    localparam logic [2:0] RST_STAGE0 = 3'b001;
    localparam logic [2:0] RST_STAGE1 = 3'b011;
    localparam logic [2:0] RST_NONE   = 3'b111;

    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level into the clk domain.
module sync_2ff (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset / lock-qualification sequencer with staged release of three domain resets.
//
// state        | meaning
// -------------+-------------------------------------------------------------
// ST_PLL_RST   | pll_rst held high for PLL_RST_CYCLES, all domains in reset
// ST_WAIT_LOCK | pll_rst low, waiting for locked_s up to LOCK_TIMEOUT cycles
// ST_STABLE    | counting STABLE_CYCLES consecutive locked_s=1 cycles
// ST_RELEASE   | releasing SDRAM, frame buffer, video timing STAGE_GAP apart
// ST_RUN       | all domains released, ready=1, watching for lock loss
// ST_FAIL      | retries exhausted, PLL and domains held in reset until sw request
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
    parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int STAGE_GAP      = DEF_STAGE_GAP,
    parameter int MAX_RETRIES    = DEF_MAX_RETRIES
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       sw_reset_req,
    output logic       pll_rst,
    output logic [2:0] rst_out_n,
    output logic       ready,
    output logic       fail,
    output logic [3:0] retry_cnt,
    output logic [7:0] lock_loss_cnt
);

    localparam int TMR_MAX = max_of4(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES, 2 * STAGE_GAP);
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] TC_PLL_RST = TMR_W'(PLL_RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] TC_LOCK    = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TC_STABLE  = TMR_W'(STABLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] TC_RELEASE = TMR_W'(2 * STAGE_GAP - 1);
    localparam logic [TMR_W-1:0] GAP_MARK   = TMR_W'(STAGE_GAP);
    localparam logic [3:0]       RETRY_MAX  = 4'(MAX_RETRIES);

    seq_state_e       state, state_nxt;
    logic [TMR_W-1:0] tmr, tmr_nxt, tmr_inc;
    logic             pll_rst_nxt;
    logic [2:0]       rst_out_n_nxt;
    logic             ready_nxt;
    logic             fail_nxt;
    logic [3:0]       retry_cnt_nxt, retry_inc;
    logic [7:0]       lock_loss_cnt_nxt;
    logic             lock_lost;
    logic             locked_s;

    sync_2ff u_sync_lock (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (pll_locked),
        .q       (locked_s)
    );

    assign tmr_inc   = tmr + TMR_W'(1);
    assign retry_inc = retry_cnt + 4'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_PLL_RST;
            tmr           <= '0;
            pll_rst       <= 1'b1;
            rst_out_n     <= RST_ALL;
            ready         <= 1'b0;
            fail          <= 1'b0;
            retry_cnt     <= 4'd0;
            lock_loss_cnt <= 8'd0;
        end else begin
            state         <= state_nxt;
            tmr           <= tmr_nxt;
            pll_rst       <= pll_rst_nxt;
            rst_out_n     <= rst_out_n_nxt;
            ready         <= ready_nxt;
            fail          <= fail_nxt;
            retry_cnt     <= retry_cnt_nxt;
            lock_loss_cnt <= lock_loss_cnt_nxt;
        end
    end

    // Every output is computed for the next state and registered, so inputs never reach outputs combinationally.
    always_comb begin
        state_nxt         = state;
        tmr_nxt           = tmr;
        pll_rst_nxt       = pll_rst;
        rst_out_n_nxt     = rst_out_n;
        ready_nxt         = ready;
        fail_nxt          = fail;
        retry_cnt_nxt     = retry_cnt;
        lock_loss_cnt_nxt = lock_loss_cnt;
        lock_lost         = 1'b0;

        if (sw_reset_req) begin
            state_nxt     = ST_PLL_RST;
            tmr_nxt       = '0;
            pll_rst_nxt   = 1'b1;
            rst_out_n_nxt = RST_ALL;
            ready_nxt     = 1'b0;
            fail_nxt      = 1'b0;
            retry_cnt_nxt = 4'd0;
        end else begin
            case (state)
                ST_PLL_RST: begin
                    pll_rst_nxt   = 1'b1;
                    rst_out_n_nxt = RST_ALL;
                    if (tmr == TC_PLL_RST) begin
                        state_nxt   = ST_WAIT_LOCK;
                        tmr_nxt     = '0;
                        pll_rst_nxt = 1'b0;
                    end else begin
                        tmr_nxt = tmr_inc;
                    end
                end

                ST_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_nxt = ST_STABLE;
                        tmr_nxt   = '0;
                    end else if (tmr == TC_LOCK) begin
                        tmr_nxt       = '0;
                        retry_cnt_nxt = retry_inc;
                        pll_rst_nxt   = 1'b1;
                        if (retry_inc == RETRY_MAX) begin
                            state_nxt = ST_FAIL;
                            fail_nxt  = 1'b1;
                        end else begin
                            state_nxt = ST_PLL_RST;
                        end
                    end else begin
                        tmr_nxt = tmr_inc;
                    end
                end

                ST_STABLE: begin
                    if (!locked_s) begin
                        state_nxt = ST_WAIT_LOCK;
                        tmr_nxt   = '0;
                    end else if (tmr == TC_STABLE) begin
                        state_nxt     = ST_RELEASE;
                        tmr_nxt       = '0;
                        rst_out_n_nxt = RST_STAGE0;
                    end else begin
                        tmr_nxt = tmr_inc;
                    end
                end

                ST_RELEASE: begin
                    if (!locked_s) begin
                        lock_lost = 1'b1;
                    end else if (tmr == TC_RELEASE) begin
                        state_nxt     = ST_RUN;
                        tmr_nxt       = '0;
                        rst_out_n_nxt = RST_NONE;
                        ready_nxt     = 1'b1;
                        retry_cnt_nxt = 4'd0;
                    end else begin
                        tmr_nxt = tmr_inc;
                        if (tmr_inc == GAP_MARK) begin
                            rst_out_n_nxt = RST_STAGE1;
                        end
                    end
                end

                ST_RUN: begin
                    if (!locked_s) begin
                        lock_lost = 1'b1;
                    end
                end

                ST_FAIL: begin
                    pll_rst_nxt   = 1'b1;
                    rst_out_n_nxt = RST_ALL;
                    fail_nxt      = 1'b1;
                end

                default: begin
                    state_nxt     = ST_PLL_RST;
                    tmr_nxt       = '0;
                    pll_rst_nxt   = 1'b1;
                    rst_out_n_nxt = RST_ALL;
                    ready_nxt     = 1'b0;
                    fail_nxt      = 1'b0;
                end
            endcase

            // A lock loss drops every domain at once and restarts the PLL.
            if (lock_lost) begin
                state_nxt     = ST_PLL_RST;
                tmr_nxt       = '0;
                pll_rst_nxt   = 1'b1;
                rst_out_n_nxt = RST_ALL;
                ready_nxt     = 1'b0;
                if (lock_loss_cnt != 8'hFF) begin
                    lock_loss_cnt_nxt = lock_loss_cnt + 8'd1;
                end
            end
        end
    end

endmodule
